data_memory: RTL and testbench



---
 rtl/data_memory.sv | 210 +++++++++++++++++++++
 tb/tb_data_memory.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: RV32I data RAM (combinational read, byte-enabled synchronous
// write) with memory-mapped LED register and 8N1 UART transmitter.
// Build option: define DMEM_UART_EN to include the UART TX FSM and its status
// register; without it the TX line idles high and status reads 0.

package riscv_pkg;
    parameter int unsigned XLEN      = 32;
    parameter int unsigned ALEN      = 32;
    parameter int unsigned LED_WIDTH = 16;
endpackage

module data_memory
    import riscv_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned MEM_WORDS    = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MemWrite,
    input  logic [3:0]           be,
    input  logic [2:0]           funct3,
    input  logic [ALEN-1:0]      Address,
    input  logic [XLEN-1:0]      WriteData,
    output logic [XLEN-1:0]      ReadData,
    output logic [LED_WIDTH-1:0] leds_out,
    output logic                 uart_tx_wire
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    localparam logic [ALEN-1:0] LED_ADDR    = ALEN'(32'h8000_0000);
    localparam logic [ALEN-1:0] TXDATA_ADDR = ALEN'(32'h8000_0004);
    localparam logic [ALEN-1:0] STATUS_ADDR = ALEN'(32'h8000_0008);

    logic [XLEN-1:0] ram_memory [0:MEM_WORDS-1];

    logic          is_mmio;
    logic          led_sel;
    logic          uart_data_sel;
    logic          status_sel;
    logic          ram_we;
    logic          led_we;
    logic [AW-1:0] word_idx;
    logic          uart_busy;

    logic [XLEN-1:0] ram_word;
    logic [7:0]      ram_byte;
    logic [15:0]     ram_half;

    assign is_mmio       = Address[ALEN-1];
    assign led_sel       = (Address == LED_ADDR);
    assign uart_data_sel = (Address == TXDATA_ADDR);
    assign status_sel    = (Address == STATUS_ADDR);
    assign word_idx      = Address[AW+1:2];
    assign ram_we        = MemWrite & ~is_mmio;
    assign led_we        = MemWrite & be[0] & led_sel;

    // RAM store: per-lane writes; no reset so preloaded contents survive
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    ram_memory[word_idx][8*i +: 8] <= WriteData[8*i +: 8];
                end
            end
        end
    end

    // LED register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds_out <= '0;
        end else if (led_we) begin
            leds_out <= WriteData[LED_WIDTH-1:0];
        end
    end

    // Load path: RAM lane select with extension, MMIO returns full words
    always_comb begin
        ram_word = ram_memory[word_idx];
        ram_half = Address[1] ? ram_word[31:16] : ram_word[15:0];
        case (Address[1:0])
            2'd0:    ram_byte = ram_word[7:0];
            2'd1:    ram_byte = ram_word[15:8];
            2'd2:    ram_byte = ram_word[23:16];
            default: ram_byte = ram_word[31:24];
        endcase

        ReadData = ram_word;
        if (is_mmio) begin
            ReadData = '0;
            if (led_sel) begin
                ReadData = XLEN'(leds_out);
            end else if (status_sel) begin
                ReadData = {{(XLEN-1){1'b0}}, uart_busy};
            end
        end else begin
            case (funct3)
                3'b000:  ReadData = {{(XLEN-8){ram_byte[7]}}, ram_byte};
                3'b001:  ReadData = {{(XLEN-16){ram_half[15]}}, ram_half};
                3'b100:  ReadData = {{(XLEN-8){1'b0}}, ram_byte};
                3'b101:  ReadData = {{(XLEN-16){1'b0}}, ram_half};
                default: ReadData = ram_word;
            endcase
        end
    end

`ifdef DMEM_UART_EN
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int unsigned   CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state, state_next;
    logic [CW-1:0] clk_cnt, clk_cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    tx_byte, tx_byte_next;
    logic          bit_done;
    logic          tx_we;

    assign tx_we = MemWrite & be[0] & uart_data_sel;

    // UART state and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            tx_byte <= '0;
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_idx <= bit_idx_next;
            tx_byte <= tx_byte_next;
        end
    end

    // UART next state: each phase lasts CLKS_PER_BIT cycles; writes while busy are dropped
    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_idx_next = bit_idx;
        tx_byte_next = tx_byte;
        bit_done     = (clk_cnt == BIT_LAST);
        case (state)
            IDLE: begin
                if (tx_we) begin
                    state_next   = START;
                    tx_byte_next = WriteData[7:0];
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    clk_cnt_next = '0;
                end else begin
                    clk_cnt_next = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_next   = IDLE;
                    clk_cnt_next = '0;
                end else begin
                    clk_cnt_next = clk_cnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // UART outputs: line level and busy flag decoded from state
    always_comb begin
        uart_busy    = (state != IDLE);
        uart_tx_wire = 1'b1;
        case (state)
            START:   uart_tx_wire = 1'b0;
            DATA:    uart_tx_wire = tx_byte[bit_idx];
            default: uart_tx_wire = 1'b1;
        endcase
    end
`else
    logic unused_uart;

    assign uart_tx_wire = 1'b1;
    assign uart_busy    = 1'b0;
    assign unused_uart  = uart_data_sel & (CLKS_PER_BIT != 0);
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed stimulus against a behavioural model of the data
// memory, LED register and UART frame timing, plus literal expectations.
`timescale 1ns/1ps

module tb_data_memory;

    localparam int unsigned CPB   = 4;
    localparam int unsigned WORDS = 1024;

    localparam logic [31:0] LED  = 32'h8000_0000;
    localparam logic [31:0] TXD  = 32'h8000_0004;
    localparam logic [31:0] STAT = 32'h8000_0008;
    localparam logic [31:0] OTHR = 32'h8000_000C;

`ifdef DMEM_UART_EN
    localparam bit UART_EN = 1'b1;
`else
    localparam bit UART_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemWrite = 1'b0;
    logic [3:0]  be = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic [15:0] leds_out;
    logic        uart_tx_wire;

    data_memory #(
        .CLKS_PER_BIT(CPB),
        .MEM_WORDS   (WORDS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MemWrite    (MemWrite),
        .be          (be),
        .funct3      (funct3),
        .Address     (Address),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .leds_out    (leds_out),
        .uart_tx_wire(uart_tx_wire)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [WORDS];
    logic [15:0] m_leds = '0;
    bit          m_busy = 1'b0;
    int unsigned m_off  = 0;     // cycles since the accepting edge
    logic [7:0]  m_byte = '0;

    always @(posedge clk or negedge rst) begin : model
        logic [31:0] w;
        logic [9:0]  idx;
        if (!rst) begin
            m_leds <= '0;
            m_busy <= 1'b0;
            m_off  <= 0;
        end else begin
            if (m_busy) begin
                if (m_off == 10*CPB - 1) m_busy <= 1'b0;
                m_off <= m_off + 1;
            end
            if (MemWrite) begin
                if (!Address[31]) begin
                    idx = 10'((Address >> 2) % WORDS);
                    w   = m_ram[idx];
                    for (int i = 0; i < 4; i++)
                        if (be[i]) w[8*i +: 8] = WriteData[8*i +: 8];
                    m_ram[idx] <= w;
                end else if (Address == LED && be[0]) begin
                    m_leds <= WriteData[15:0];
                end else if (Address == TXD && be[0] && UART_EN && !m_busy) begin
                    m_busy <= 1'b1;
                    m_off  <= 0;
                    m_byte <= WriteData[7:0];
                end
            end
        end
    end

    function automatic logic exp_line();
        logic [7:0] sh;
        if (!m_busy) return 1'b1;
        if (m_off < CPB) return 1'b0;
        if (m_off < 9*CPB) begin
            sh = m_byte >> ((m_off - CPB) / CPB);
            return sh[0];
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w, b, h;
        logic [9:0]  idx;
        if (a[31]) begin
            if (a == LED)  return {16'h0, m_leds};
            if (a == STAT) return {31'h0, m_busy};
            return 32'h0;
        end
        idx = 10'((a >> 2) % WORDS);
        w = m_ram[idx];
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128)   ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Every cycle: LED register and serial line against the model
    always @(negedge clk) begin
        chk("leds", 64'(leds_out), 64'(m_leds));
        chk("uart_line", 64'(uart_tx_wire), 64'(exp_line()));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        Address = a; WriteData = d; be = b; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0; be = '0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] lit);
        Address = a; funct3 = f3; MemWrite = 1'b0; be = '0;
        #1;
        chk(name, 64'(ReadData), 64'(model_load(a, f3)));
        chk({name, "_lit"}, 64'(ReadData), 64'(lit));
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [39:0] line_v, busy_v;
        int lows;

        #1;
        chk("reset_leds", 64'(leds_out), 64'h0);
        chk("reset_line", 64'(uart_tx_wire), 64'h1);
        tick(); tick();
        rst = 1'b1;
        tick();

        // word store then every load flavour
        store(32'h100, 32'h8000_00F1, 4'b1111);
        rd("lb_100",  32'h100, 3'b000, 32'hFFFF_FFF1);
        rd("lbu_100", 32'h100, 3'b100, 32'h0000_00F1);
        rd("lh_102",  32'h102, 3'b001, 32'hFFFF_8000);
        rd("lhu_102", 32'h102, 3'b101, 32'h0000_8000);
        rd("lh_103",  32'h103, 3'b001, 32'hFFFF_8000);
        rd("lb_103",  32'h103, 3'b000, 32'hFFFF_FF80);
        rd("lw_100",  32'h100, 3'b010, 32'h8000_00F1);
        rd("f3_011",  32'h100, 3'b011, 32'h8000_00F1);
        rd("wrap",    32'h1100, 3'b010, 32'h8000_00F1);

        // byte enables
        store(32'h200, 32'h1122_3344, 4'b1111);
        store(32'h200, 32'hAABB_CCDD, 4'b0100);
        rd("be_0100", 32'h200, 3'b010, 32'h11BB_3344);
        store(32'h200, 32'hFFFF_FFFF, 4'b0000);
        rd("be_0000", 32'h200, 3'b010, 32'h11BB_3344);

        // read-during-write returns old data, next cycle new
        store(32'h300, 32'h0102_0304, 4'b1111);
        Address = 32'h300; funct3 = 3'b010; WriteData = 32'hDEAD_BEEF; be = 4'b1111; MemWrite = 1'b1;
        #1;
        chk("rdw_old", 64'(ReadData), 64'(model_load(32'h300, 3'b010)));
        chk("rdw_old_lit", 64'(ReadData), 64'h0102_0304);
        tick();
        MemWrite = 1'b0; be = '0;
        rd("rdw_new", 32'h300, 3'b010, 32'hDEAD_BEEF);

        // LED
        store(LED, 32'h0000_00A5, 4'b1111);
        chk("led_a5", 64'(leds_out), 64'hA5);
        rd("led_lw", LED, 3'b010, 32'h0000_00A5);
        rd("led_lb", LED, 3'b000, 32'h0000_00A5);
        store(LED, 32'h0000_00FF, 4'b1110);
        chk("led_no_be0", 64'(leds_out), 64'hA5);
        store(LED, 32'h1234_5678, 4'b1111);
        chk("led_trunc", 64'(leds_out), 64'h5678);

        // unmapped MMIO and TX data readback
        store(OTHR, 32'hFFFF_FFFF, 4'b1111);
        rd("mmio_other", OTHR, 3'b010, 32'h0);
        rd("txd_read",   TXD,  3'b010, 32'h0);
        rd("status_idle", STAT, 3'b010, 32'h0);

        // UART frame of 0x55 with a dropped second write
        store(TXD, 32'h0000_0055, 4'b0001);
        for (int j = 0; j < 40; j++) begin
            Address = STAT; funct3 = 3'b010; #1;
            line_v[j] = uart_tx_wire;
            busy_v[j] = ReadData[0];
            chk("status_frame", 64'(ReadData), 64'(model_load(STAT, 3'b010)));
            if (j == 10) begin
                Address = TXD; WriteData = 32'h0000_00FF; be = 4'b0001; MemWrite = 1'b1;
            end
            tick();
            MemWrite = 1'b0; be = '0;
        end
        chk("frame_line_lit", 64'(line_v), UART_EN ? 64'hF0_F0F0_F0F0 : 64'hFF_FFFF_FFFF);
        chk("frame_busy_lit", 64'(busy_v), UART_EN ? 64'hFF_FFFF_FFFF : 64'h0);
        rd("status_done", STAT, 3'b010, 32'h0);
        lows = 0;
        for (int j = 0; j < 45; j++) begin
            if (uart_tx_wire !== 1'b1) lows++;
            tick();
        end
        chk("dropped_write", 64'(lows), 64'h0);

        // reset mid-frame
        store(TXD, 32'h0000_0000, 4'b0001);
        repeat (5) tick();
        #2 rst = 1'b0;
        #1;
        chk("rst_line", 64'(uart_tx_wire), 64'h1);
        chk("rst_leds", 64'(leds_out), 64'h0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rd("rst_ram_100", 32'h100, 3'b010, 32'h8000_00F1);
        rd("rst_ram_200", 32'h200, 3'b010, 32'h11BB_3344);
        rd("rst_status",  STAT, 3'b010, 32'h0);

        // a fresh frame after reset, checked cycle by cycle against the model
        store(TXD, 32'h0000_00A3, 4'b0001);
        repeat (42) tick();
        rd("status_end", STAT, 3'b010, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
